// File: rtl/viterbi_dec_if.sv
// Bit-serial channel interface of the Viterbi decoder: the receive stream in,
// decoded bits and status out.
interface viterbi_dec_if;
    logic data_in;
    logic dec_en;
    logic data_out;
    logic dec_out_valid;
    logic dec_busy;

    // Source side: drives the received channel bits and watches the decoder status.
    modport master (
        output data_in,
        output dec_en,
        input  data_out,
        input  dec_out_valid,
        input  dec_busy
    );

    // Decoder side.
    modport slave (
        input  data_in,
        input  dec_en,
        output data_out,
        output dec_out_valid,
        output dec_busy
    );
endinterface

// File: rtl/viterbi_dec.sv
// Hard-decision Viterbi decoder for the rate-1/2, K=3 code (g0=111 -> A, g1=101 -> B).
// The received stream arrives one bit per clock, B first then A. The decoder runs a
// 4-state trellis and keeps its survivors in register-exchange form.
module viterbi_dec #(
    parameter int TB_LEN = 15,
    parameter int PM_W   = 6
) (
    input logic   dec_clk,
    input logic   reset,
    viterbi_dec_if.slave bus
);

    localparam int CW = $clog2(TB_LEN + 1);
    localparam logic [PM_W-1:0] PM_INIT = {2'b01, {(PM_W-2){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [PM_W-1:0]   pm [4];
    logic [TB_LEN-1:0] sv [4];
    logic              phase;
    logic              b_bit;
    logic [CW-1:0]     sym_cnt;
    logic [CW-1:0]     drain_cnt;
    logic              data_out_r;
    logic              valid_r;
    logic              busy_r;

    logic [PM_W-1:0]   new_pm [4];
    logic [TB_LEN-1:0] new_sv [4];
    logic [1:0]        best;
    logic [CW-1:0]     drain_m;
    logic [CW-1:0]     drain_idx;

    assign bus.data_out      = data_out_r;
    assign bus.dec_out_valid = valid_r;
    assign bus.dec_busy      = busy_r;

    // Add-compare-select for all four next states, followed by MSB normalisation.
    always_comb begin
        logic [1:0]      rx;
        logic [1:0]      exp0;
        logic [1:0]      exp1;
        logic [1:0]      d0;
        logic [1:0]      d1;
        logic [PM_W-1:0] cand0;
        logic [PM_W-1:0] cand1;
        logic [1:0]      pred0;
        logic [1:0]      pred1;
        logic            u;
        logic            p;
        logic            all_msb;
        rx      = {b_bit, bus.data_in};
        all_msb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            new_pm[i] = '0;
            new_sv[i] = '0;
        end
        for (int i = 0; i < 4; i++) begin
            u     = i[1];
            p     = i[0];
            pred0 = {p, 1'b0};
            pred1 = {p, 1'b1};
            exp0  = {u, u ^ p};
            exp1  = {~u, ~(u ^ p)};
            d0    = rx ^ exp0;
            d1    = rx ^ exp1;
            cand0 = pm[pred0] + {{(PM_W-2){1'b0}}, ({1'b0, d0[1]} + {1'b0, d0[0]})};
            cand1 = pm[pred1] + {{(PM_W-2){1'b0}}, ({1'b0, d1[1]} + {1'b0, d1[0]})};
            if (cand1 < cand0) begin
                new_pm[i] = cand1;
                new_sv[i] = {sv[pred1][TB_LEN-2:0], u};
            end else begin
                new_pm[i] = cand0;
                new_sv[i] = {sv[pred0][TB_LEN-2:0], u};
            end
            all_msb = all_msb & new_pm[i][PM_W-1];
        end
        if (all_msb) begin
            for (int i = 0; i < 4; i++) begin
                new_pm[i][PM_W-1] = 1'b0;
            end
        end
    end

    // Best state is the smallest metric, lowest index on ties; also the drain bookkeeping.
    always_comb begin
        logic [PM_W-1:0] best_pm;
        best    = 2'd0;
        best_pm = pm[0];
        for (int i = 1; i < 4; i++) begin
            if (pm[i] < best_pm) begin
                best    = 2'(i);
                best_pm = pm[i];
            end
        end
        drain_m   = (sym_cnt < CW'(TB_LEN - 1)) ? sym_cnt : CW'(TB_LEN - 1);
        drain_idx = drain_cnt - CW'(1);
    end

    // Control FSM with registered outputs; reset and end-of-drain share the re-initialisation.
    always_ff @(posedge dec_clk) begin
        valid_r <= 1'b0;
        if (reset || (state == DRAIN && drain_cnt == '0)) begin
            state     <= IDLE;
            busy_r    <= 1'b0;
            phase     <= 1'b0;
            b_bit     <= 1'b0;
            sym_cnt   <= '0;
            drain_cnt <= '0;
            pm[0]     <= '0;
            for (int i = 1; i < 4; i++) begin
                pm[i] <= PM_INIT;
            end
            for (int i = 0; i < 4; i++) begin
                sv[i] <= '0;
            end
            if (reset) begin
                data_out_r <= 1'b0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.dec_en) begin
                        state  <= RUN;
                        busy_r <= 1'b1;
                        b_bit  <= bus.data_in;
                        phase  <= 1'b1;
                    end
                end
                RUN: begin
                    if (!phase && sym_cnt == CW'(TB_LEN)) begin
                        data_out_r <= sv[best][TB_LEN-1];
                        valid_r    <= 1'b1;
                    end
                    if (!bus.dec_en) begin
                        phase <= 1'b0;
                        if (sym_cnt == '0) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            state     <= DRAIN;
                            drain_cnt <= drain_m;
                        end
                    end else if (!phase) begin
                        b_bit <= bus.data_in;
                        phase <= 1'b1;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            pm[i] <= new_pm[i];
                            sv[i] <= new_sv[i];
                        end
                        phase <= 1'b0;
                        if (sym_cnt != CW'(TB_LEN)) begin
                            sym_cnt <= sym_cnt + CW'(1);
                        end
                    end
                end
                DRAIN: begin
                    data_out_r <= sv[best][drain_idx];
                    valid_r    <= 1'b1;
                    drain_cnt  <= drain_idx;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule
